tv80_bus_bridge: RTL and testbench
==================================

# tv80_bus_bridge

Converts the registered Z80 pin strobes from the TV80 wrapper (`mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `rfsh_n`) into a single-outstanding valid/ready request plus response handshake toward the on-chip memory/IO fabric. It sits directly downstream of the CPU wrapper: it consumes `A`/`dout`, and drives `di` and `wait_n` back to the CPU. It stretches CPU cycles with `wait_n` until the fabric answers, then adds parameterised minimum wait states. Interrupt-acknowledge cycles are answered locally with a vector.

## Interface
- `MEM_WAIT`, default 0: extra `cen` cycles of wait after a memory access completes.
- `IO_WAIT`, default 1: extra `cen` cycles of wait after an IO access or interrupt-acknowledge completes.
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cen`  in  1  CPU clock enable; same signal fed to the CPU.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `rfsh_n`  in  1 each  CPU bus strobes, active low.
- `A`  in  16  CPU address.
- `dout`  in  8  CPU write data.
- `di`  out  8  read data / interrupt vector to CPU.
- `wait_n`  out  1  CPU wait request, active low.
- `int_vec`  in  8  vector returned on interrupt acknowledge.
- `req_valid`  out  1  fabric request valid.
- `req_we`  out  1  1 = write.
- `req_io`  out  1  1 = IO space, 0 = memory.
- `req_addr`  out  16  latched `A`.
- `req_wdata`  out  8  latched `dout`.
- `req_ready`  in  1  fabric accepts the request.
- `rsp_valid`  in  1  read data valid (reads only).
- `rsp_rdata`  in  8  read data.

## Operation
- `start` = `cen` & state IDLE & `rfsh_n` & one of:
  - mem read: `!mreq_n & !rd_n`
  - mem write: `!mreq_n & !wr_n`
  - IO read: `!iorq_n & !rd_n & m1_n`
  - IO write: `!iorq_n & !wr_n`
  - INTA: `!iorq_n & !m1_n`
- Refresh cycles (`rfsh_n`=0) and strobes with neither `mreq_n` nor `iorq_n` low are ignored.
- States:
  - IDLE: on `start`, latch `A`, `dout`, we, io and kind. INTA goes to DELAY with `di`<=`int_vec`; any other access goes to REQ.
  - REQ: `req_valid`=1 with stable fields. On `req_ready`, a write goes to DELAY and a read goes to RSP.
  - RSP: on `rsp_valid`, set `di`<=`rsp_rdata` and go to DELAY.
  - DELAY: load the counter with `MEM_WAIT` or `IO_WAIT` on entry. Decrement on `cen`. When it reaches 0, go to HOLD.
  - HOLD: `wait_n`=1. Return to IDLE on the first `cen` cycle with `rd_n` & `wr_n` & (`iorq_n` | `m1_n`) all high. This prevents retriggering within one strobe.
- `wait_n` = !(`start` | state∈{REQ, RSP, DELAY}). This is combinational so the CPU sees wait in the same cycle the strobe is first detected.
- `req_*` fields are held unchanged from IDLE exit until HOLD. `req_valid` is high only in REQ.
- `di` holds its last value outside updates; the CPU samples it only while `wait_n`=1.
- `rsp_valid` outside RSP is ignored. `req_ready` outside REQ is ignored.
- Counter width is 8 bits. Parameters above 255 are illegal (elaboration assertion).

## Timing
- Reset values: `wait_n`=1, `req_valid`=0, `req_we`=0, `req_io`=0, `req_addr`=0, `req_wdata`=0, `di`=0, state IDLE, counter 0.
- Fabric handshakes advance every `clk`, independent of `cen`. Strobe sampling, DELAY counting and HOLD release advance only on `cen`.
- Minimum latency from the `start` cycle to `wait_n`=1:
  - memory write with `req_ready` already high and `MEM_WAIT`=0: 2 `clk` (REQ, DELAY).
  - read: 1 extra `clk` per RSP cycle.
- `req_ready` and `rsp_valid` both high in REQ for a read: only `req_ready` is taken; the response is consumed in RSP.
- Strobe deassertion while in REQ/RSP/DELAY (CPU abort, unsupported) does not abort the transaction; the bridge completes it and HOLD releases immediately.
- `reset_n` low mid-transaction: all state and outputs return to reset values asynchronously, and `req_valid` drops at once. The fabric must tolerate a dropped request.

## Structure
- Package `tv80_bus_pkg`:
  - state enum {IDLE, REQ, RSP, DELAY, HOLD}
  - access-kind enum {MEM_RD, MEM_WR, IO_RD, IO_WR, INTA}
  - the `start` decode as a function
- Single module; no sub-module. Decode is small. The wait counter stays inline.

## Test plan
- Memory read at `A`=16'h1234, `rsp_rdata`=8'hA5 after 3 clk, `MEM_WAIT`=0 → `req_valid` with addr 16'h1234 and we=0; `wait_n` low until `rsp_valid`; `di`=8'hA5 when `wait_n` rises.
- IO write `A`=16'h00FE, `dout`=8'h3C, `IO_WAIT`=2, `cen` every other clk → `req_io`=1, `req_we`=1, `req_wdata`=8'h3C; `wait_n` stays low 2 `cen` cycles past `req_ready`.
- INTA with `int_vec`=8'hF7 → no `req_valid`; `di`=8'hF7 after `IO_WAIT` cen cycles.
- Refresh cycle (`rfsh_n`=0, `mreq_n`=0) → no request, `wait_n`=1 throughout.
- `req_ready` held low 10 clk → `req_valid` and fields stable for all 10 clk; `wait_n` low throughout.
- `reset_n` pulsed low in RSP → `req_valid`=0, `wait_n`=1, `di`=0 immediately. Next read completes normally.

Source files
------------

// File: rtl/tv80_bus_pkg.sv
// Shared types and strobe decode for the TV80 bus bridge.
package tv80_bus_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = 255;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RSP,
        DELAY,
        HOLD
    } state_e;

    typedef enum logic [2:0] {
        MEM_RD,
        MEM_WR,
        IO_RD,
        IO_WR,
        INTA
    } kind_e;

    typedef struct packed {
        logic  hit;
        kind_e kind;
    } decode_t;

    // Classify the current strobe pattern; refresh and idle buses never hit.
    function automatic decode_t decode_strobes(
        input logic mreq_n,
        input logic iorq_n,
        input logic rd_n,
        input logic wr_n,
        input logic m1_n,
        input logic rfsh_n
    );
        decode_t d;
        d.hit  = 1'b0;
        d.kind = MEM_RD;
        if (rfsh_n) begin
            if (!mreq_n && !rd_n) begin
                d.hit  = 1'b1;
                d.kind = MEM_RD;
            end else if (!mreq_n && !wr_n) begin
                d.hit  = 1'b1;
                d.kind = MEM_WR;
            end else if (!iorq_n && !m1_n) begin
                d.hit  = 1'b1;
                d.kind = INTA;
            end else if (!iorq_n && !rd_n) begin
                d.hit  = 1'b1;
                d.kind = IO_RD;
            end else if (!iorq_n && !wr_n) begin
                d.hit  = 1'b1;
                d.kind = IO_WR;
            end
        end
        return d;
    endfunction

    function automatic logic kind_is_write(input kind_e k);
        return (k == MEM_WR) || (k == IO_WR);
    endfunction

    function automatic logic kind_is_io(input kind_e k);
        return (k == IO_RD) || (k == IO_WR) || (k == INTA);
    endfunction

endpackage

// File: rtl/tv80_bus_bridge.sv
// Turns TV80 bus strobes into a single-outstanding valid/ready fabric request,
// stretching the CPU with wait_n until the fabric answers plus a minimum wait.
module tv80_bus_bridge
    import tv80_bus_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cen,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              m1_n,
    input  logic              rfsh_n,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] di,
    output logic              wait_n,
    input  logic [DATA_W-1:0] int_vec,
    output logic              req_valid,
    output logic              req_we,
    output logic              req_io,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata
);

    if (MEM_WAIT > CNT_MAX || IO_WAIT > CNT_MAX) begin : g_bad_param
        $error("tv80_bus_bridge: wait parameters must not exceed %0d", CNT_MAX);
    end

    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_WAIT);

    state_e           state;
    kind_e            kind;
    logic [CNT_W-1:0] cnt;
    decode_t          dec_c;
    logic             start_c;
    logic [CNT_W-1:0] load_c;
    logic             release_c;

    assign dec_c = decode_strobes(mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n);

    // Gated by reset_n so wait_n reads released while the bridge is held in reset.
    assign start_c = reset_n & cen & (state == IDLE) & dec_c.hit;

    // Combinational so the CPU is stalled in the very cycle the strobe is seen.
    assign wait_n = ~(start_c | (state == REQ) | (state == RSP) | (state == DELAY));

    assign load_c    = kind_is_io(kind) ? IO_LOAD : MEM_LOAD;
    assign release_c = cen & rd_n & wr_n & (iorq_n | m1_n);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            kind      <= MEM_RD;
            cnt       <= '0;
            di        <= '0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_io    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        kind      <= dec_c.kind;
                        req_addr  <= A;
                        req_wdata <= dout;
                        req_we    <= kind_is_write(dec_c.kind);
                        req_io    <= kind_is_io(dec_c.kind);
                        if (dec_c.kind == INTA) begin
                            di    <= int_vec;
                            cnt   <= IO_LOAD;
                            state <= DELAY;
                        end else begin
                            req_valid <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if (kind_is_write(kind)) begin
                            cnt   <= load_c;
                            state <= DELAY;
                        end else begin
                            state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (rsp_valid) begin
                        di    <= rsp_rdata;
                        cnt   <= load_c;
                        state <= DELAY;
                    end
                end
                DELAY: begin
                    // Zero count exits without waiting for cen; each cen consumes one wait state.
                    if (cnt == '0) begin
                        state <= HOLD;
                    end else if (cen) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Wait for the strobe to drop so one CPU cycle cannot start twice.
                    if (release_c) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Randomized and directed bench for tv80_bus_bridge against a cycle-schedule model.
module tb_tv80_bus_bridge;

    localparam int unsigned MEM_W = 0;
    localparam int unsigned IO_W  = 2;

    localparam int K_MEM_RD = 0;
    localparam int K_MEM_WR = 1;
    localparam int K_IO_RD  = 2;
    localparam int K_IO_WR  = 3;
    localparam int K_INTA   = 4;

    logic        clk;
    logic        reset_n;
    logic        cen;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic [7:0]  di;
    logic        wait_n;
    logic [7:0]  int_vec;
    logic        req_valid, req_we, req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;

    int unsigned tests;
    int unsigned fails;
    int unsigned cyc;
    int unsigned cen_p;
    logic [7:0]  model_di;

    tv80_bus_bridge #(.MEM_WAIT(MEM_W), .IO_WAIT(IO_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cen       (cen),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .m1_n      (m1_n),
        .rfsh_n    (rfsh_n),
        .A         (A),
        .dout      (dout),
        .di        (di),
        .wait_n    (wait_n),
        .int_vec   (int_vec),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_io    (req_io),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_cen_period(input int unsigned p);
        cen_p = p;
        cen   = (cyc % cen_p) == 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        cen = (cyc % cen_p) == 0;
    endtask

    task automatic set_strobes(input int k);
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
        case (k)
            K_MEM_RD: begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'($urandom_range(0, 1)); end
            K_MEM_WR: begin mreq_n = 1'b0; wr_n = 1'b0; end
            K_IO_RD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
            K_IO_WR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
            K_INTA:   begin iorq_n = 1'b0; m1_n = 1'b0; end
            default:  ;
        endcase
    endtask

    // Cycle after the w-th cen at or beyond d0: the final cycle the CPU is still stalled.
    function automatic int unsigned last_low(input int unsigned d0, input int unsigned w,
                                             input int unsigned p);
        int unsigned n;
        int unsigned k;
        n = d0;
        k = 0;
        while (k < w) begin
            if (n % p == 0) k++;
            n++;
        end
        return n;
    endfunction

    task automatic idle(input int unsigned cycles);
        set_strobes(-1);
        for (int i = 0; i < int'(cycles); i++) begin
            req_ready = 1'($urandom_range(0, 1));
            rsp_valid = 1'($urandom_range(0, 1));
            rsp_rdata = 8'($urandom);
            @(negedge clk);
            check("idle_wait_n", 32'(wait_n), 32'd1);
            check("idle_req_valid", 32'(req_valid), 32'd0);
            next_cycle();
        end
    endtask

    task automatic run_access(input int k, input logic [15:0] addr, input logic [7:0] wdata,
                              input logic [7:0] rdata, input logic [7:0] ivec,
                              input int unsigned rd, input int unsigned sd,
                              input int unsigned hold_extra);
        int unsigned s, d0, rsp_c, last, end_c, w;
        logic is_rd, is_wr, is_io;
        is_wr = (k == K_MEM_WR) || (k == K_IO_WR);
        is_rd = (k == K_MEM_RD) || (k == K_IO_RD);
        is_io = (k == K_IO_RD) || (k == K_IO_WR) || (k == K_INTA);
        w     = is_io ? IO_W : MEM_W;
        set_strobes(k);
        A       = addr;
        dout    = wdata;
        int_vec = ivec;
        s = cyc;
        while (s % cen_p != 0) s++;
        rsp_c = s + 2 + rd + sd;
        if (k == K_INTA)  d0 = s + 1;
        else if (is_wr)   d0 = s + 2 + rd;
        else              d0 = rsp_c + 1;
        last  = last_low(d0, w, cen_p);
        end_c = last + 1 + hold_extra;
        if (k == K_INTA)  model_di = ivec;
        else if (is_rd)   model_di = rdata;
        while (cyc <= end_c) begin
            if (k != K_INTA && cyc >= s + 1 && cyc <= s + 1 + rd)
                req_ready = (cyc == s + 1 + rd);
            else
                req_ready = 1'($urandom_range(0, 1));
            if (is_rd && cyc >= s + 2 + rd && cyc <= rsp_c)
                rsp_valid = (cyc == rsp_c);
            else
                rsp_valid = 1'($urandom_range(0, 1));
            rsp_rdata = (is_rd && cyc == rsp_c) ? rdata : 8'($urandom);
            @(negedge clk);
            check("wait_n", 32'(wait_n), 32'(!(cyc >= s && cyc <= last)));
            check("req_valid", 32'(req_valid),
                  32'(k != K_INTA && cyc >= s + 1 && cyc <= s + 1 + rd));
            if (cyc > s) begin
                check("req_addr", 32'(req_addr), 32'(addr));
                check("req_wdata", 32'(req_wdata), 32'(wdata));
                check("req_we", 32'(req_we), 32'(is_wr));
                check("req_io", 32'(req_io), 32'(is_io));
            end
            if (cyc > last) check("di", 32'(di), 32'(model_di));
            next_cycle();
        end
        idle(2 * cen_p + 1);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; cen_p = 1;
        reset_n = 1'b0; cen = 1'b0;
        set_strobes(-1);
        A = '0; dout = '0; int_vec = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        model_di = '0;

        #3;
        check("rst_wait_n", 32'(wait_n), 32'd1);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_we", 32'(req_we), 32'd0);
        check("rst_req_io", 32'(req_io), 32'd0);
        check("rst_req_addr", 32'(req_addr), 32'd0);
        check("rst_req_wdata", 32'(req_wdata), 32'd0);
        check("rst_di", 32'(di), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        next_cycle();
        set_cen_period(1);
        idle(2);

        // Memory read, response 3 clk after request
        run_access(K_MEM_RD, 16'h1234, 8'h00, 8'hA5, 8'h00, 0, 2, 1);
        // IO write with cen every other clk
        set_cen_period(2);
        run_access(K_IO_WR, 16'h00FE, 8'h3C, 8'h00, 8'h00, 1, 0, 2);
        // Interrupt acknowledge at both cen rates
        run_access(K_INTA, 16'h0038, 8'h00, 8'h00, 8'hF7, 0, 0, 1);
        set_cen_period(1);
        run_access(K_INTA, 16'h0000, 8'h00, 8'h00, 8'h6B, 0, 0, 0);

        // Refresh must be ignored
        mreq_n = 1'b0; rd_n = 1'b0; rfsh_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rfsh_wait_n", 32'(wait_n), 32'd1);
            check("rfsh_req_valid", 32'(req_valid), 32'd0);
            next_cycle();
        end
        idle(2);

        // Fabric stalls 10 clk, then ready already high for a fastest-path write
        run_access(K_MEM_WR, 16'hC0DE, 8'h99, 8'h00, 8'h00, 10, 0, 0);
        run_access(K_MEM_WR, 16'h8001, 8'h11, 8'h00, 8'h00, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            set_cen_period($urandom_range(1, 3));
            run_access(int'($urandom_range(0, 4)), 16'($urandom), 8'($urandom), 8'($urandom),
                       8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 2));
        end

        // Reset while waiting for a read response
        set_cen_period(1);
        run_access(K_MEM_RD, 16'h4321, 8'h00, 8'h5A, 8'h00, 0, 1, 0);
        set_strobes(K_MEM_RD);
        A = 16'hBEEF;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        next_cycle();
        next_cycle();
        req_ready = 1'b0;
        @(negedge clk);
        check("rsp_wait_n", 32'(wait_n), 32'd0);
        check("rsp_di_before_rst", 32'(di), 32'h5A);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(req_valid), 32'd0);
        check("arst_wait_n", 32'(wait_n), 32'd1);
        check("arst_di", 32'(di), 32'd0);
        check("arst_req_addr", 32'(req_addr), 32'd0);
        set_strobes(-1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc++;
        cen = (cyc % cen_p) == 0;
        model_di = '0;
        idle(2);
        run_access(K_MEM_RD, 16'h2468, 8'h00, 8'hC3, 8'h00, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
